// File: rtl/checker_mode_scan_if.sv
// -----------------------------------------------------------------------------
// checker_mode_scan_if
// Bundles the control-side (mode_*) and memory-side (mem_*) signals of the
// quad-word pattern scanner.
//   master : scanner view. Receives run requests, hit acks and read responses.
//            Drives the result pulses and data, and the memory read request.
//   slave  : environment view. Controller plus memory, with the opposite
//            directions.
// Signals:
//   mode_start  run request (low aborts)      mode_addr  byte start address
//   mode_ack    hit acknowledge               mode_end   scan complete pulse
//   mode_error  memory error pulse            mode_irq   hit pulse
//   mode_data   result word                   mem_req    read request
//   mem_addr    read byte address             mem_ack    read complete
//   mem_data    read data                     mem_err    read failed
// -----------------------------------------------------------------------------
interface checker_mode_scan_if;
  logic        mode_start;
  logic [63:0] mode_addr;
  logic        mode_ack;
  logic        mode_end;
  logic        mode_error;
  logic        mode_irq;
  logic [63:0] mode_data;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [63:0] mem_data;
  logic        mem_err;

  modport master (
    input  mode_start, mode_addr, mode_ack, mem_ack, mem_data, mem_err,
    output mode_end, mode_error, mode_irq, mode_data, mem_req, mem_addr
  );

  modport slave (
    output mode_start, mode_addr, mode_ack, mem_ack, mem_data, mem_err,
    input  mode_end, mode_error, mode_irq, mode_data, mem_req, mem_addr
  );
endinterface

// File: rtl/checker_mode_scan.sv
// -----------------------------------------------------------------------------
// checker_mode_scan
// Reads SCAN_QWORDS consecutive quad words, starting at an 8-byte aligned
// address. It raises an interrupt for every word equal to MAGIC and waits for
// an acknowledge before it continues. At the end it reports the hit count. On
// a read error it reports the failing address.
// Ports:
//   sys_clk    single clock, rising edge
//   sys_rst_n  asynchronous active-low reset
//   bus        checker_mode_scan_if.master (control and memory signals)
// -----------------------------------------------------------------------------
module checker_mode_scan #(
  parameter logic [31:0] SCAN_QWORDS = 32'd512,
  parameter logic [63:0] MAGIC       = 64'hFEEDFACE_CAFEBEEF
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  checker_mode_scan_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, HIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [63:0] ptr_q, ptr_d;
  logic [31:0] remaining_q, remaining_d;
  logic [31:0] hits_q, hits_d;
  logic        drain_q, drain_d;
  logic        mem_req_q, mem_req_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic        end_q, end_d;
  logic        error_q, error_d;
  logic        irq_q, irq_d;
  logic [63:0] data_q, data_d;
  logic [63:0] start_addr;
  logic        mem_resp;

  assign start_addr = bus.mode_addr & 64'hFFFF_FFFF_FFFF_FFF8;
  assign mem_resp   = bus.mem_ack | bus.mem_err;

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mode_end   = end_q;
  assign bus.mode_error = error_q;
  assign bus.mode_irq   = irq_q;
  assign bus.mode_data  = data_q;

  // State and output registers. All outputs are registered, so reset clears
  // them at once without waiting for a clock edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      remaining_q <= '0;
      hits_q      <= '0;
      drain_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      end_q       <= 1'b0;
      error_q     <= 1'b0;
      irq_q       <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remaining_q <= remaining_d;
      hits_q      <= hits_d;
      drain_q     <= drain_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      end_q       <= end_d;
      error_q     <= error_d;
      irq_q       <= irq_d;
      data_q      <= data_d;
    end
  end

  // Next-state logic. The three result strobes default to zero, so each one
  // lasts exactly one cycle. Aborting with a read outstanding leaves mem_req
  // high, and the drain flag throws that read's result away.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    remaining_d = remaining_q;
    hits_d      = hits_q;
    drain_d     = drain_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    end_d       = 1'b0;
    error_d     = 1'b0;
    irq_d       = 1'b0;
    data_d      = data_q;

    if (drain_q && mem_resp) begin
      drain_d   = 1'b0;
      mem_req_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (bus.mode_start && !drain_q) begin
          ptr_d       = start_addr;
          remaining_d = SCAN_QWORDS;
          hits_d      = '0;
          mem_req_d   = 1'b1;
          mem_addr_d  = start_addr;
          state_d     = REQ;
        end
      end

      REQ: begin
        if (!bus.mode_start) begin
          state_d = IDLE;
          if (mem_resp) mem_req_d = 1'b0;
          else          drain_d   = 1'b1;
        end else if (bus.mem_err) begin
          mem_req_d = 1'b0;
          error_d   = 1'b1;
          data_d    = ptr_q;
          state_d   = DONE;
        end else if (bus.mem_ack) begin
          ptr_d       = ptr_q + 64'd8;
          remaining_d = remaining_q - 32'd1;
          if (bus.mem_data == MAGIC) begin
            data_d    = ptr_q;
            irq_d     = 1'b1;
            mem_req_d = 1'b0;
            state_d   = HIT;
            if (hits_q != 32'hFFFF_FFFF) hits_d = hits_q + 32'd1;
          end else if (remaining_q == 32'd1) begin
            data_d    = {32'b0, hits_q};
            end_d     = 1'b1;
            mem_req_d = 1'b0;
            state_d   = DONE;
          end else begin
            mem_addr_d = ptr_d;
          end
        end
      end

      HIT: begin
        if (!bus.mode_start) begin
          state_d = IDLE;
        end else if (bus.mode_ack) begin
          if (remaining_q == 32'd0) begin
            data_d  = {32'b0, hits_q};
            end_d   = 1'b1;
            state_d = DONE;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = ptr_q;
            state_d    = REQ;
          end
        end
      end

      DONE: begin
        if (!bus.mode_start) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_checker_mode_scan.sv
// -----------------------------------------------------------------------------
// tb_checker_mode_scan
// Drives checker_mode_scan (4 quad words per run) from a memory responder
// with random latency and from a controller that acknowledges hits. Observed
// reads and result pulses are compared with a reference model that walks the
// address range.
// -----------------------------------------------------------------------------
module tb_checker_mode_scan;
  localparam logic [63:0] MAGIC_TB = 64'hFEEDFACE_CAFEBEEF;
  localparam int          NQ       = 4;

  logic sys_clk;
  logic sys_rst_n;

  checker_mode_scan_if bus();

  checker_mode_scan #(
    .SCAN_QWORDS(32'd4),
    .MAGIC      (MAGIC_TB)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks   = 0;
  int failures = 0;

  bit          is_magic[logic [63:0]];
  bit          err_en;
  logic [63:0] err_addr;
  int          min_lat;
  int          max_lat;
  logic [63:0] obs_reads[$];
  int          proto_err;

  logic [63:0] exp_reads[$];
  logic [1:0]  exp_kind[$];
  logic [63:0] exp_data[$];

  // Event kinds: 1 = irq, 2 = end, 3 = error.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clearMem();
    is_magic.delete();
    err_en   = 1'b0;
    err_addr = '0;
  endtask

  // Reference: visit the aligned addresses in order. An error address stops
  // the walk. A MAGIC word counts as a hit. The scan ends with the hit count.
  task automatic buildModel(input logic [63:0] start);
    logic [63:0] a;
    int          hits;
    exp_reads.delete();
    exp_kind.delete();
    exp_data.delete();
    a    = start & ~64'h7;
    hits = 0;
    for (int i = 0; i < NQ; i++) begin
      exp_reads.push_back(a);
      if (err_en && a == err_addr) begin
        exp_kind.push_back(2'd3);
        exp_data.push_back(a);
        return;
      end
      if (is_magic.exists(a)) begin
        hits++;
        exp_kind.push_back(2'd1);
        exp_data.push_back(a);
      end
      a = a + 64'd8;
    end
    exp_kind.push_back(2'd2);
    exp_data.push_back(64'(hits));
  endtask

  // Memory responder with protocol watch. Once mem_req is high, it must not
  // drop and its address must not change until a response has been given.
  initial begin
    int          wait_cnt;
    logic        prev_req;
    logic        prev_resp;
    logic [63:0] prev_addr;
    logic [63:0] d;
    bus.mem_ack  = 1'b0;
    bus.mem_err  = 1'b0;
    bus.mem_data = '0;
    wait_cnt  = -1;
    prev_req  = 1'b0;
    prev_resp = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        bus.mem_ack = 1'b0;
        bus.mem_err = 1'b0;
        wait_cnt    = -1;
        prev_req    = 1'b0;
        prev_resp   = 1'b0;
      end else begin
        if (prev_req && !prev_resp) begin
          if (!bus.mem_req) proto_err++;
          else if (bus.mem_addr != prev_addr) proto_err++;
        end
        prev_req    = bus.mem_req;
        prev_addr   = bus.mem_addr;
        bus.mem_ack = 1'b0;
        bus.mem_err = 1'b0;
        if (bus.mem_req) begin
          if (wait_cnt < 0) wait_cnt = int'($urandom_range(max_lat, min_lat));
          if (wait_cnt == 0) begin
            obs_reads.push_back(bus.mem_addr);
            d = {$urandom, $urandom};
            if (d == MAGIC_TB) d = ~d;
            if (err_en && bus.mem_addr == err_addr) begin
              bus.mem_err  = 1'b1;
              bus.mem_ack  = 1'($urandom_range(1, 0));
              bus.mem_data = MAGIC_TB;
            end else begin
              bus.mem_ack  = 1'b1;
              bus.mem_data = is_magic.exists(bus.mem_addr) ? MAGIC_TB : d;
            end
            wait_cnt = -1;
          end else begin
            wait_cnt--;
          end
        end
        prev_resp = bus.mem_ack | bus.mem_err;
      end
    end
  end

  // One scan run. A positive abort_at drops mode_start at that cycle.
  task automatic applyStimulus(input logic [63:0] addr, input int abort_at,
                               input bit expect_hold);
    int          cycles;
    bit          done;
    bit          aborted;
    bit          in_hit;
    bit          drained;
    int          ack_cnt;
    int          n;
    int          multi;
    int          hit_bad;
    int          quiet_bad;
    int          pulses;
    logic [63:0] hit_data;
    logic [1:0]  ev_kind[$];
    logic [63:0] ev_data[$];

    buildModel(addr);
    obs_reads.delete();
    proto_err = 0;
    multi     = 0;
    hit_bad   = 0;
    quiet_bad = 0;
    done      = 1'b0;
    aborted   = 1'b0;
    in_hit    = 1'b0;
    ack_cnt   = 0;
    hit_data  = '0;
    cycles    = 0;

    bus.mode_addr  = {addr[63:3], 3'($urandom_range(7, 0))};
    bus.mode_start = 1'b1;

    while (!done && !aborted && cycles < 200) begin
      @(negedge sys_clk);
      cycles++;
      bus.mode_ack = 1'b0;
      n = int'(bus.mode_irq) + int'(bus.mode_end) + int'(bus.mode_error);
      if (n > 1) multi++;
      if (bus.mode_irq) begin
        ev_kind.push_back(2'd1);
        ev_data.push_back(bus.mode_data);
        in_hit   = 1'b1;
        hit_data = bus.mode_data;
        ack_cnt  = int'($urandom_range(3, 0));
      end
      if (bus.mode_end) begin
        ev_kind.push_back(2'd2);
        ev_data.push_back(bus.mode_data);
        done = 1'b1;
      end
      if (bus.mode_error) begin
        ev_kind.push_back(2'd3);
        ev_data.push_back(bus.mode_data);
        done = 1'b1;
      end
      if (in_hit) begin
        if (bus.mem_req || bus.mode_data != hit_data) hit_bad++;
        if (ack_cnt == 0) begin
          bus.mode_ack = 1'b1;
          in_hit       = 1'b0;
        end else begin
          ack_cnt--;
        end
      end
      if (!done && abort_at > 0 && cycles == abort_at) begin
        bus.mode_start = 1'b0;
        aborted        = 1'b1;
      end
    end
    checkOutput("run_bounded", done | aborted, 1);

    if (aborted) begin
      pulses  = 0;
      drained = 1'b0;
      for (int i = 0; i < 20 && !drained; i++) begin
        @(negedge sys_clk);
        bus.mode_ack = 1'b0;
        if (i == 0 && expect_hold) checkOutput("abort_hold_req", bus.mem_req, 1);
        if (bus.mode_irq || bus.mode_end || bus.mode_error) pulses++;
        if (!bus.mem_req) drained = 1'b1;
      end
      repeat (2) @(negedge sys_clk);
      checkOutput("abort_drained", drained, 1);
      checkOutput("abort_no_pulse", pulses, 0);
      checkOutput("abort_reads_len", obs_reads.size() <= exp_reads.size(), 1);
      foreach (obs_reads[i])
        if (i < exp_reads.size()) checkOutput("abort_read_addr", obs_reads[i], exp_reads[i]);
      checkOutput("abort_evt_len", ev_kind.size() < exp_kind.size(), 1);
      foreach (ev_kind[i])
        if (i < exp_kind.size()) begin
          checkOutput("abort_evt_kind", ev_kind[i], exp_kind[i]);
          checkOutput("abort_evt_data", ev_data[i], exp_data[i]);
        end
    end else begin
      checkOutput("read_count", obs_reads.size(), exp_reads.size());
      foreach (exp_reads[i])
        if (i < obs_reads.size()) checkOutput("read_addr", obs_reads[i], exp_reads[i]);
      checkOutput("event_count", ev_kind.size(), exp_kind.size());
      foreach (exp_kind[i])
        if (i < ev_kind.size()) begin
          checkOutput("event_kind", ev_kind[i], exp_kind[i]);
          checkOutput("event_data", ev_data[i], exp_data[i]);
        end
      for (int i = 0; i < 4; i++) begin
        @(negedge sys_clk);
        bus.mode_ack = (i == 1);
        if (bus.mode_irq || bus.mode_end || bus.mode_error || bus.mem_req) quiet_bad++;
      end
      bus.mode_ack   = 1'b0;
      bus.mode_start = 1'b0;
      repeat (2) @(negedge sys_clk);
      checkOutput("done_quiet", quiet_bad, 0);
    end
    checkOutput("one_hot", multi, 0);
    checkOutput("hit_hold", hit_bad, 0);
    checkOutput("mem_proto", proto_err, 0);
  endtask

  // Async reset while waiting in HIT: outputs must clear before any clock
  // edge, and a fresh run afterwards must behave normally.
  task automatic resetDuringHit();
    bit seen;
    seen = 1'b0;
    clearMem();
    is_magic[64'h2008] = 1'b1;
    min_lat = 0;
    max_lat = 1;
    bus.mode_addr  = 64'h2000;
    bus.mode_start = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge sys_clk);
      if (bus.mode_irq) seen = 1'b1;
    end
    checkOutput("rst_hit_irq", seen, 1);
    checkOutput("rst_hit_data", bus.mode_data, 64'h2008);
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1;
    checkOutput("rst_async_data", bus.mode_data, 0);
    checkOutput("rst_async_addr", bus.mem_addr, 0);
    checkOutput("rst_async_flags",
                {bus.mem_req, bus.mode_end, bus.mode_error, bus.mode_irq}, 0);
    bus.mode_start = 1'b0;
    @(negedge sys_clk);
    #2 sys_rst_n = 1'b1;
    applyStimulus(64'h2000, -1, 1'b0);
  endtask

  initial begin
    logic [63:0] base;
    logic [63:0] a;
    int          abort_at;

    sys_rst_n      = 1'b0;
    bus.mode_start = 1'b0;
    bus.mode_addr  = '0;
    bus.mode_ack   = 1'b0;
    clearMem();
    min_lat   = 0;
    max_lat   = 0;
    proto_err = 0;

    @(negedge sys_clk);
    checkOutput("reset_mem_req", bus.mem_req, 0);
    checkOutput("reset_mem_addr", bus.mem_addr, 0);
    checkOutput("reset_mode_data", bus.mode_data, 0);
    checkOutput("reset_pulses", {bus.mode_end, bus.mode_error, bus.mode_irq}, 0);
    #2 sys_rst_n = 1'b1;
    @(negedge sys_clk);

    $display("[TB] plain scan, no matches");
    clearMem();
    min_lat = 0;
    max_lat = 0;
    applyStimulus(64'h1000, -1, 1'b0);

    $display("[TB] single hit at 0x1008");
    clearMem();
    is_magic[64'h1008] = 1'b1;
    max_lat = 2;
    applyStimulus(64'h1000, -1, 1'b0);

    $display("[TB] error at 0x1010");
    clearMem();
    err_en   = 1'b1;
    err_addr = 64'h1010;
    applyStimulus(64'h1005, -1, 1'b0);

    $display("[TB] abort with read pending");
    clearMem();
    min_lat = 4;
    max_lat = 4;
    applyStimulus(64'h3000, 2, 1'b1);

    $display("[TB] address wrap");
    clearMem();
    min_lat = 0;
    max_lat = 1;
    is_magic[64'h0] = 1'b1;
    applyStimulus(64'hFFFF_FFFF_FFFF_FFF8, -1, 1'b0);

    $display("[TB] reset during hit");
    resetDuringHit();

    $display("[TB] random runs");
    for (int r = 0; r < 30; r++) begin
      clearMem();
      if ($urandom_range(3, 0) == 0)
        base = 64'hFFFF_FFFF_FFFF_FFE0 + 64'($urandom_range(3, 0)) * 64'd8;
      else
        base = {$urandom, $urandom};
      a = base & ~64'h7;
      for (int i = 0; i < NQ; i++) begin
        if ($urandom_range(2, 0) == 0) is_magic[a] = 1'b1;
        a = a + 64'd8;
      end
      err_en   = ($urandom_range(3, 0) == 0);
      err_addr = (base & ~64'h7) + 64'($urandom_range(3, 0)) * 64'd8;
      min_lat  = 0;
      max_lat  = int'($urandom_range(3, 0));
      abort_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(10, 1)) : -1;
      applyStimulus(base, abort_at, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/checker_mode_scan.md
CHECKER_MODE_SCAN -- requirements
Module: checker_mode_scan

Interface
REQ-001 SHALL have parameter SCAN_QWORDS, default 32'd512, meaning the number of quad words scanned per run (minimum 1).
REQ-002 SHALL have parameter MAGIC, default 64'hFEEDFACE_CAFEBEEF, meaning the quad-word pattern that raises a hit.
REQ-003 SHALL have port sys_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port mode_start, input, 1 bit: run request from the control interface; low aborts the run.
REQ-006 SHALL have port mode_addr, input, 64 bits: byte start address, 8-byte aligned (bits [2:0] ignored); stable while mode_start is high.
REQ-007 SHALL have port mode_ack, input, 1 bit: one-cycle acknowledge of a hit.
REQ-008 SHALL have port mode_end, output, 1 bit: one-cycle pulse when the scan completes.
REQ-009 SHALL have port mode_error, output, 1 bit: one-cycle pulse on a memory error.
REQ-010 SHALL have port mode_irq, output, 1 bit: one-cycle pulse on a hit.
REQ-011 SHALL have port mode_data, output, 64 bits: result word (see Function).
REQ-012 SHALL have port mem_req, output, 1 bit: memory read request, held high until mem_ack or mem_err.
REQ-013 SHALL have port mem_addr, output, 64 bits: byte address of the read; stable while mem_req is high.
REQ-014 SHALL have port mem_ack, input, 1 bit: read completes, with mem_data valid in the same cycle.
REQ-015 SHALL have port mem_data, input, 64 bits: read data.
REQ-016 SHALL have port mem_err, input, 1 bit: read failed; takes priority over mem_ack in the same cycle.

Function
REQ-017 SHALL implement the states IDLE, REQ, HIT, DONE.
REQ-018 SHALL, in IDLE with mode_start=1, load ptr={mode_addr[63:3],3'b0}, remaining=SCAN_QWORDS and hits=0, then enter REQ with mem_req=1 on the next cycle.
REQ-019 SHALL, in REQ, drive mem_addr=ptr.
REQ-020 SHALL, in REQ on mem_err, drop mem_req, pulse mode_error, set mode_data={ptr}, and enter DONE.
REQ-021 SHALL, in REQ on mem_ack with mem_data==MAGIC, set mode_data=ptr, pulse mode_irq, increment hits (saturating at 2^32-1), advance ptr by 8, decrement remaining, and enter HIT.
REQ-022 SHALL, in REQ on mem_ack with a non-matching word, advance ptr by 8 and decrement remaining; if remaining becomes 0, set mode_data={32'b0,hits}, pulse mode_end, and enter DONE; otherwise re-issue the request with a back-to-back mem_req permitted.
REQ-023 SHALL, in HIT, keep mem_req=0 and mode_data unchanged, and wait for mode_ack; on mode_ack, if remaining==0 it SHALL pulse mode_end with mode_data={32'b0,hits} and enter DONE, else it SHALL enter REQ.
REQ-024 SHALL, in DONE, stay until mode_start=0, then return to IDLE; a run never restarts while mode_start stays high.
REQ-025 SHALL, on mode_start=0 in REQ or HIT, abort to IDLE the next cycle without pulsing end, error or irq.
REQ-026 SHALL, on an abort while mem_req is high, keep mem_req asserted until mem_ack or mem_err and discard that result (internal drain flag).
REQ-027 SHALL wrap ptr modulo 2^64, with no error on wrap.
REQ-028 SHALL ignore mode_ack outside HIT.
REQ-029 SHALL never assert more than one of mode_end, mode_error and mode_irq in the same cycle.

Reset
REQ-030 SHALL, while sys_rst_n=0, immediately force state=IDLE, mem_req=0, mem_addr=0, mode_end=0, mode_error=0, mode_irq=0, mode_data=0, hits=0 and drain=0.
REQ-031 SHALL, after sys_rst_n is released mid-run, sit in IDLE and require mode_start to be seen high to begin a run.

Verification
REQ-032 SHALL cover: SCAN_QWORDS=4, addr 0x1000, no matches, mem_ack one cycle after each req -> reads at 0x1000/08/10/18, one mode_end pulse, mode_data=0.
REQ-033 SHALL cover: word at 0x1008 == MAGIC -> mode_irq pulse with mode_data=0x1008 and no mem_req until mode_ack; after ack, reads resume at 0x1010 and end with mode_data=1.
REQ-034 SHALL cover: mem_err on the read of 0x1010 -> one mode_error pulse, mode_data=0x1010, DONE until mode_start=0.
REQ-035 SHALL cover: mode_start dropped while mem_req is pending -> mem_req held until mem_ack, no pulses, IDLE afterwards.
REQ-036 SHALL cover: mode_addr=0xFFFF_FFFF_FFFF_FFF8, SCAN_QWORDS=2 -> reads at 0xFFFF_FFFF_FFFF_FFF8 then 0x0, then mode_end.
REQ-037 SHALL cover: sys_rst_n pulsed low asynchronously during HIT -> all outputs 0 without a clock edge, and a new run starts cleanly.
